// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared width helpers and grant index type for the FIFO push arbiter
package fifo_arb_pkg;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter width: must hold the values 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return clog2_min1(depth + 1);
  endfunction

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_GRANT_W = clog2_min1(DEF_N_REQ);

  typedef logic [DEF_GRANT_W-1:0] grant_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at rr_ptr and wraps
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [clog2_min1(N_REQ)-1:0]  rr_ptr,
  output logic                          grant_present,
  output logic [clog2_min1(N_REQ)-1:0]  grant_id
);

  localparam int GW = clog2_min1(N_REQ);

  // Walk from the farthest slot back to rr_ptr so the nearest request wins last
  always_comb begin
    int idx;
    grant_present = 1'b0;
    grant_id      = '0;
    idx           = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) begin
        grant_present = 1'b1;
        grant_id      = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_push_ctrl.sv
// rtl/fifo_rr_push_ctrl.sv - round-robin push controller for a flagless FIFO (option: FIFO_ARB_FULL_PUSH_EN)
module fifo_rr_push_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WIDTH-1:0]        req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_push,
  output logic                          fifo_pop,
  output logic [WIDTH-1:0]              fifo_wr_data,
  input  logic [WIDTH-1:0]              fifo_rd_data,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic [clog2_min1(N_REQ)-1:0]  grant_id
);

  localparam int GW = clog2_min1(N_REQ);
  localparam int CW = cnt_width(DEPTH);

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] arb_id;
  logic          grant_present;
  logic          can_push;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req           (req_valid),
    .rr_ptr        (rr_ptr),
    .grant_present (grant_present),
    .grant_id      (arb_id)
  );

  // Space check; the optional path lets a full FIFO refill the slot a pop is vacating
  always_comb begin
`ifdef FIFO_ARB_FULL_PUSH_EN
    can_push = (count < CW'(DEPTH)) | (out_ready & (count == CW'(DEPTH)));
`else
    can_push = (count < CW'(DEPTH));
`endif
  end

  // Handshake strobes, all forced low while reset is held
  always_comb begin
    out_valid = (count != '0) & ~rst;
    fifo_pop  = out_valid & out_ready;
    fifo_push = grant_present & can_push & ~rst;
    req_ready = '0;
    if (fifo_push) begin
      req_ready[arb_id] = 1'b1;
    end
  end

  // Data steering: granted producer to the FIFO, FIFO head straight to the consumer
  always_comb begin
    fifo_wr_data = req_data[int'(arb_id)*WIDTH +: WIDTH];
    out_data     = fifo_rd_data;
    grant_id     = arb_id;
  end

  // Pointer moves past the winner only on an accepted push, so a stalled grant stays put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (fifo_push) begin
      rr_ptr <= (arb_id == GW'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
    end
  end

  // Occupancy tracking; push and pop together leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Sim-only guard that the FIFO is never overrun or underrun
  always @(posedge clk) begin
    if (!rst) begin
`ifdef FIFO_ARB_FULL_PUSH_EN
      assert (!fifo_push || (count < CW'(DEPTH)) || (fifo_pop && (count == CW'(DEPTH))));
`else
      assert (!fifo_push || (count < CW'(DEPTH)));
`endif
      assert (!fifo_pop || (count != '0));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_push_ctrl.sv
// tb/tb_fifo_rr_push_ctrl.sv - self-checking bench for fifo_rr_push_ctrl against a queue model
module tb_fifo_rr_push_ctrl;
  import fifo_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_push;
  logic             fifo_pop;
  logic [W-1:0]     fifo_wr_data;
  logic [W-1:0]     fifo_rd_data;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [1:0]       count;
  grant_id_t        grant_id;

  always #5 clk = ~clk;

  fifo_rr_push_ctrl #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_push    (fifo_push),
    .fifo_pop     (fifo_pop),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .grant_id     (grant_id)
  );

  // Flagless pointer FIFO standing in for the shared instance
  logic [W-1:0] mem [D];
  int           wp;
  int           rp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (fifo_push) begin
        mem[wp] <= fifo_wr_data;
        wp      <= (wp + 1) % D;
      end
      if (fifo_pop) rp <= (rp + 1) % D;
    end
  end
  assign fifo_rd_data = mem[rp];

  // Reference model: queue of stored words plus the next-search start index
  logic [W-1:0] q[$];
  int           ptr;
  logic [W-1:0] dat [N];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic ordy, input bit rnd);
    for (int i = 0; i < N; i++) begin
      dat[i] = rnd ? W'($urandom) : W'(32'hA0 + i);
      req_data[i*W +: W] = dat[i];
    end
    req_valid = v;
    out_ready = ordy;
  endtask

  // One clock: drive after the edge, check at the falling edge, advance the model
  task automatic cycle(input logic [N-1:0] v, input logic ordy, input bit rnd);
    int g;
    bit can, ep, eo;
    logic [N-1:0] er;
    drive(v, ordy, rnd);
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    end
`ifdef FIFO_ARB_FULL_PUSH_EN
    can = (q.size() < D) || (ordy && q.size() == D);
`else
    can = (q.size() < D);
`endif
    ep = (g >= 0) && can;
    eo = (q.size() > 0) && ordy;
    er = '0;
    if (ep) er[g] = 1'b1;
    chk("count", W'(count), W'(q.size()));
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("fifo_push", W'(fifo_push), W'(ep));
    chk("fifo_pop", W'(fifo_pop), W'(eo));
    chk("req_ready", W'(req_ready), W'(er));
    if (ep) begin
      chk("grant_id", W'(grant_id), W'(g));
      chk("fifo_wr_data", fifo_wr_data, dat[g]);
    end
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    if (eo) void'(q.pop_front());
    if (ep) begin
      q.push_back(dat[g]);
      ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    model_reset();
    @(negedge clk);
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_fifo_push", W'(fifo_push), '0);
    chk("rst_fifo_pop", W'(fifo_pop), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_count", W'(count), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill from all producers with the consumer stalled, then drain
    repeat (3) cycle(4'b1111, 1'b0, 1'b0);
    repeat (4) cycle(4'b1111, 1'b1, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0);

    // Park the pointer on 3, then alternate between producers 3 and 0
    cycle(4'b0100, 1'b0, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0);
    repeat (5) cycle(4'b1001, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);

    // Fill, then reset mid-stream and check the outputs drop at once
    repeat (3) cycle(4'b0110, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_count", W'(count), '0);
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_req_ready", W'(req_ready), '0);
    chk("midrst_fifo_push", W'(fifo_push), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(4'b1111, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
